// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, byte width
// and the default WAIT-state timeout.
package uart_pkg;

  localparam int BYTE_W        = 8;
  localparam int TO_CYCLES_DEF = 1000000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

endpackage : uart_pkg

// File: rtl/req_buf.sv
// One-entry holding buffer for a single requester, with a sticky overflow
// flag that records strobes dropped while the buffer was occupied.
module req_buf
  import uart_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] data,
  input  logic              valid,
  input  logic              drain,
  input  logic              ovf_clr,
  output logic [BYTE_W-1:0] data_q,
  output logic              full,
  output logic              ovf
);

  logic accept;
  logic drop;

  // A strobe is taken when the slot is free or is being emptied this cycle.
  always_comb begin
    accept = valid && (!full || drain);
    drop   = valid && full && !drain;
  end

  // Buffer occupancy, stored byte and sticky drop flag (set beats clear).
  always_ff @(posedge clk) begin
    if (rst) begin
      full   <= 1'b0;
      // NOTE: the data register is reset too so tx_data can never expose a stale byte after reset.
      data_q <= '0;
      ovf    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (accept) begin
        full   <= 1'b1;
        data_q <= data;
      end else if (drain) begin
        full   <= 1'b0;
      end
      if (drop)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

endmodule : req_buf

// File: rtl/uart_tx_arb.sv
// Two-requester arbiter feeding a single UART transmitter. Each requester has
// a one-byte holding buffer; a round-robin FSM launches one byte at a time and
// waits for tx_done, aborting after TO_CYCLES cycles. All outputs are flops.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int TO_CYCLES = TO_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] req0_data,
  input  logic              req0_valid,
  output logic              req0_full,
  input  logic [BYTE_W-1:0] req1_data,
  input  logic              req1_valid,
  output logic              req1_full,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_start,
  input  logic              tx_done,
  output logic [1:0]        grant,
  output logic [1:0]        ovf,
  input  logic              ovf_clr,
  output logic              timeout
);

  localparam int CNT_W = $clog2(TO_CYCLES);

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt;
  logic              prio;        // 0: requester 0 favoured, 1: requester 1
  logic              sel;         // requester picked in IDLE
  logic              any_full;
  logic              drain0, drain1;
  logic              wait_exit;
  logic              to_hit;
  logic [BYTE_W-1:0] buf0_q, buf1_q;
  logic [BYTE_W-1:0] tx_data_d;
  logic [1:0]        grant_d;
  logic              tx_start_d;
  logic              timeout_d;

  req_buf u_buf0 (
    .clk     (clk),
    .rst     (rst),
    .data    (req0_data),
    .valid   (req0_valid),
    .drain   (drain0),
    .ovf_clr (ovf_clr),
    .data_q  (buf0_q),
    .full    (req0_full),
    .ovf     (ovf[0])
  );

  req_buf u_buf1 (
    .clk     (clk),
    .rst     (rst),
    .data    (req1_data),
    .valid   (req1_valid),
    .drain   (drain1),
    .ovf_clr (ovf_clr),
    .data_q  (buf1_q),
    .full    (req1_full),
    .ovf     (ovf[1])
  );

  // State register, WAIT cycle counter and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      prio  <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= (state == ST_WAIT && state_d == ST_WAIT) ? cnt + 1'b1 : '0;
      if (wait_exit) prio <= ~grant[1];
    end
  end

  // Next-state logic: round-robin pick in IDLE, done/timeout exit from WAIT.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    state_d   = state;
    drain0    = 1'b0;
    drain1    = 1'b0;
    wait_exit = 1'b0;
    to_hit    = 1'b0;
    any_full  = req0_full || req1_full;
    sel       = (req0_full && req1_full) ? prio : req1_full;
    unique case (state)
      ST_IDLE: begin
        if (any_full) begin
          state_d = ST_START;
          drain0  = !sel;
          drain1  = sel;
        end
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        if (tx_done) begin
          state_d   = ST_IDLE;
          wait_exit = 1'b1;
        end else if (cnt == CNT_W'(TO_CYCLES - 1)) begin
          state_d   = ST_IDLE;
          wait_exit = 1'b1;
          to_hit    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: next values for the registered transmitter-side outputs.
  always_comb begin
    tx_data_d  = tx_data;
    grant_d    = grant;
    tx_start_d = 1'b0;
    timeout_d  = to_hit;
    if (state == ST_IDLE && any_full) begin
      tx_data_d  = sel ? buf1_q : buf0_q;
      grant_d    = sel ? 2'b10 : 2'b01;
      tx_start_d = 1'b1;
    end else if (wait_exit) begin
      grant_d    = 2'b00;
    end
  end

  // Output registers; tx_data and grant only change on launch or WAIT exit.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data  <= '0;
      grant    <= 2'b00;
      tx_start <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      tx_data  <= tx_data_d;
      grant    <= grant_d;
      tx_start <= tx_start_d;
      timeout  <= timeout_d;
    end
  end

endmodule : uart_tx_arb

// File: tb/tb_uart_tx_arb.sv
// Directed self-checking bench for uart_tx_arb. A default-parameter instance
// covers the data path; a TO_CYCLES=8 instance on the same inputs covers timeout.
module tb_uart_tx_arb;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req0_data = '0, req1_data = '0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       tx_done = 1'b0, ovf_clr = 1'b0;

  logic       req0_full, req1_full, tx_start, timeout;
  logic [7:0] tx_data;
  logic [1:0] grant, ovf;

  logic       t_req0_full, t_req1_full, t_tx_start, t_timeout;
  logic [7:0] t_tx_data;
  logic [1:0] t_grant, t_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx_arb dut (
    .clk(clk), .rst(rst),
    .req0_data(req0_data), .req0_valid(req0_valid), .req0_full(req0_full),
    .req1_data(req1_data), .req1_valid(req1_valid), .req1_full(req1_full),
    .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done),
    .grant(grant), .ovf(ovf), .ovf_clr(ovf_clr), .timeout(timeout)
  );

  uart_tx_arb #(.TO_CYCLES(8)) dut_to (
    .clk(clk), .rst(rst),
    .req0_data(req0_data), .req0_valid(req0_valid), .req0_full(t_req0_full),
    .req1_data(req1_data), .req1_valid(req1_valid), .req1_full(t_req1_full),
    .tx_data(t_tx_data), .tx_start(t_tx_start), .tx_done(tx_done),
    .grant(t_grant), .ovf(t_ovf), .ovf_clr(ovf_clr), .timeout(t_timeout)
  );

  // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at "cycle 0": first cycle with rst low and reset outputs visible.
  task automatic do_reset();
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    tx_done = 1'b0; ovf_clr = 1'b0; req0_data = '0; req1_data = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (req0_full !== 1'b0) begin n_fail++; $display("FAIL reset_full0: got %b want 0", req0_full); end
    n_checks++; if (req1_full !== 1'b0) begin n_fail++; $display("FAIL reset_full1: got %b want 0", req1_full); end
    n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    n_checks++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b want 00", grant); end
    n_checks++; if (ovf !== 2'b00) begin n_fail++; $display("FAIL reset_ovf: got %b want 00", ovf); end
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", timeout); end
    n_checks++; if (t_grant !== 2'b00 || t_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_to_dut: got grant=%b timeout=%b want 00/0", t_grant, t_timeout); end
  endtask

  task automatic test_single();
    do_reset();
    req0_data = 8'h41; req0_valid = 1'b1;              // cycle 0
    tick(); req0_valid = 1'b0;                          // cycle 1
    n_checks++; if (req0_full !== 1'b1) begin n_fail++; $display("FAIL single_full_c1: got %b want 1", req0_full); end
    n_checks++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL single_nostart_c1: got %b want 0", tx_start); end
    tick();                                             // cycle 2
    n_checks++; if (tx_start !== 1'b1) begin n_fail++; $display("FAIL single_start_c2: got %b want 1", tx_start); end
    n_checks++; if (tx_data !== 8'h41) begin n_fail++; $display("FAIL single_data_c2: got %h want 41", tx_data); end
    n_checks++; if (grant !== 2'b01) begin n_fail++; $display("FAIL single_grant_c2: got %b want 01", grant); end
    tick();                                             // cycle 3
    n_checks++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL single_pulse_c3: got %b want 0", tx_start); end
    repeat (17) tick();                                 // cycle 20
    n_checks++; if (grant !== 2'b01 || tx_data !== 8'h41) begin n_fail++; $display("FAIL single_stable_c20: got grant=%b data=%h want 01/41", grant, tx_data); end
    tx_done = 1'b1;
    tick(); tx_done = 1'b0;                             // cycle 21
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL single_grant_c21: got %b want 00", grant); end
    tick();                                             // cycle 22
    n_checks++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL single_idle_c22: got %b want 0", tx_start); end
  endtask

  task automatic test_contention();
    do_reset();
    req0_data = 8'h11; req1_data = 8'h22;
    req0_valid = 1'b1; req1_valid = 1'b1;               // cycle 0
    tick(); req0_valid = 1'b0; req1_valid = 1'b0;       // cycle 1
    n_checks++; if ({req1_full, req0_full} !== 2'b11) begin n_fail++; $display("FAIL cont_full_c1: got %b want 11", {req1_full, req0_full}); end
    tick();                                             // cycle 2
    n_checks++; if (tx_start !== 1'b1 || tx_data !== 8'h11 || grant !== 2'b01) begin n_fail++; $display("FAIL cont_first: got start=%b data=%h grant=%b want 1/11/01", tx_start, tx_data, grant); end
    n_checks++; if ({req1_full, req0_full} !== 2'b10) begin n_fail++; $display("FAIL cont_full_c2: got %b want 10", {req1_full, req0_full}); end
    tick(); tx_done = 1'b1;                             // cycle 3
    tick(); tx_done = 1'b0;                             // cycle 4
    n_checks++; if (grant !== 2'b00 || tx_start !== 1'b0) begin n_fail++; $display("FAIL cont_gap_c4: got grant=%b start=%b want 00/0", grant, tx_start); end
    tick();                                             // cycle 5
    n_checks++; if (tx_start !== 1'b1 || tx_data !== 8'h22 || grant !== 2'b10) begin n_fail++; $display("FAIL cont_second: got start=%b data=%h grant=%b want 1/22/10", tx_start, tx_data, grant); end
    tick(); tx_done = 1'b1;                             // cycle 6
    tick(); tx_done = 1'b0;                             // cycle 7
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL cont_grant_c7: got %b want 00", grant); end
    for (int c = 8; c < 13; c++) begin
      tick();
      n_checks++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL cont_no_resend c%0d: got %b want 0", c, tx_start); end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    req0_data = 8'hA0; req0_valid = 1'b1;               // cycle 0
    tick(); req0_valid = 1'b0;                          // cycle 1
    tick();                                             // cycle 2 (START)
    tick(); req1_data = 8'h33; req1_valid = 1'b1;       // cycle 3 (WAIT)
    tick(); req1_data = 8'h44;                          // cycle 4
    n_checks++; if (req1_full !== 1'b1 || ovf !== 2'b00) begin n_fail++; $display("FAIL ovf_load: got full1=%b ovf=%b want 1/00", req1_full, ovf); end
    tick(); req1_data = 8'h66; ovf_clr = 1'b1;          // cycle 5
    n_checks++; if (ovf !== 2'b10) begin n_fail++; $display("FAIL ovf_set: got %b want 10", ovf); end
    tick(); req1_valid = 1'b0; ovf_clr = 1'b0;          // cycle 6
    n_checks++; if (ovf !== 2'b10) begin n_fail++; $display("FAIL ovf_set_wins: got %b want 10", ovf); end
    tx_done = 1'b1;
    tick(); tx_done = 1'b0;                             // cycle 7
    tick();                                             // cycle 8
    n_checks++; if (tx_start !== 1'b1 || tx_data !== 8'h33 || grant !== 2'b10) begin n_fail++; $display("FAIL ovf_send33: got start=%b data=%h grant=%b want 1/33/10", tx_start, tx_data, grant); end
    ovf_clr = 1'b1;
    tick(); ovf_clr = 1'b0; tx_done = 1'b1;             // cycle 9
    n_checks++; if (ovf !== 2'b00) begin n_fail++; $display("FAIL ovf_clear: got %b want 00", ovf); end
    tick(); tx_done = 1'b0;                             // cycle 10
    tick();                                             // cycle 11
    n_checks++; if (tx_start !== 1'b0 || req1_full !== 1'b0) begin n_fail++; $display("FAIL ovf_dropped: got start=%b full1=%b want 0/0", tx_start, req1_full); end
  endtask

  task automatic test_drain_accept();
    do_reset();
    req0_data = 8'h50; req0_valid = 1'b1;               // cycle 0
    tick(); req0_data = 8'h55;                          // cycle 1: buf0 drained this cycle
    tick(); req0_valid = 1'b0;                          // cycle 2 (START)
    n_checks++; if (tx_start !== 1'b1 || tx_data !== 8'h50) begin n_fail++; $display("FAIL drain_first: got start=%b data=%h want 1/50", tx_start, tx_data); end
    n_checks++; if (req0_full !== 1'b1 || ovf !== 2'b00) begin n_fail++; $display("FAIL drain_accept: got full0=%b ovf=%b want 1/00", req0_full, ovf); end
    tx_done = 1'b1;                                     // ignored outside WAIT
    tick(); tx_done = 1'b0;                             // cycle 3
    n_checks++; if (grant !== 2'b01 || tx_start !== 1'b0) begin n_fail++; $display("FAIL drain_done_ignored: got grant=%b start=%b want 01/0", grant, tx_start); end
    tick(); tx_done = 1'b1;                             // cycle 4
    tick(); tx_done = 1'b0;                             // cycle 5
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL drain_idle: got %b want 00", grant); end
    tick();                                             // cycle 6
    n_checks++; if (tx_start !== 1'b1 || tx_data !== 8'h55 || grant !== 2'b01 || req0_full !== 1'b0) begin n_fail++; $display("FAIL drain_second: got start=%b data=%h grant=%b full0=%b want 1/55/01/0", tx_start, tx_data, grant, req0_full); end
  endtask

  task automatic test_timeout();
    do_reset();
    req0_data = 8'h77; req1_data = 8'h88;
    req0_valid = 1'b1; req1_valid = 1'b1;               // cycle 0
    tick(); req0_valid = 1'b0; req1_valid = 1'b0;       // cycle 1
    tick();                                             // cycle 2 (START)
    n_checks++; if (t_tx_start !== 1'b1 || t_tx_data !== 8'h77 || t_grant !== 2'b01) begin n_fail++; $display("FAIL to_first: got start=%b data=%h grant=%b want 1/77/01", t_tx_start, t_tx_data, t_grant); end
    for (int c = 3; c <= 10; c++) begin
      tick();
      req0_valid = (c == 9);
      req0_data  = 8'h99;
      n_checks++; if (t_timeout !== 1'b0 || t_grant !== 2'b01) begin n_fail++; $display("FAIL to_wait c%0d: got timeout=%b grant=%b want 0/01", c, t_timeout, t_grant); end
    end
    tick(); req0_valid = 1'b0;                          // cycle 11
    n_checks++; if (t_timeout !== 1'b1 || t_grant !== 2'b00 || t_tx_start !== 1'b0) begin n_fail++; $display("FAIL to_pulse: got timeout=%b grant=%b start=%b want 1/00/0", t_timeout, t_grant, t_tx_start); end
    tick();                                             // cycle 12
    n_checks++; if (t_timeout !== 1'b0) begin n_fail++; $display("FAIL to_one_cycle: got %b want 0", t_timeout); end
    n_checks++; if (t_tx_start !== 1'b1 || t_tx_data !== 8'h88 || t_grant !== 2'b10) begin n_fail++; $display("FAIL to_next_rr: got start=%b data=%h grant=%b want 1/88/10", t_tx_start, t_tx_data, t_grant); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req0_data = 8'hC0; req1_data = 8'hC1;
    req0_valid = 1'b1; req1_valid = 1'b1;               // cycle 0
    tick(); req0_valid = 1'b0; req1_valid = 1'b0;       // cycle 1
    tick();                                             // cycle 2 (START)
    tick(); req0_data = 8'hC2; req0_valid = 1'b1;       // cycle 3 (WAIT)
    tick(); req0_valid = 1'b0; rst = 1'b1;              // cycle 4: both buffers full
    n_checks++; if ({req1_full, req0_full} !== 2'b11 || grant !== 2'b01) begin n_fail++; $display("FAIL rstmid_pre: got full=%b grant=%b want 11/01", {req1_full, req0_full}, grant); end
    tick(); rst = 1'b0;                                 // cycle 5
    n_checks++; if ({req1_full, req0_full} !== 2'b00 || grant !== 2'b00 || tx_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_state: got full=%b grant=%b data=%h want 00/00/00", {req1_full, req0_full}, grant, tx_data); end
    n_checks++; if (tx_start !== 1'b0 || timeout !== 1'b0 || ovf !== 2'b00) begin n_fail++; $display("FAIL rstmid_pulses: got start=%b timeout=%b ovf=%b want 0/0/00", tx_start, timeout, ovf); end
    for (int c = 6; c < 10; c++) begin
      tick();
      n_checks++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL rstmid_quiet c%0d: got %b want 0", c, tx_start); end
    end
    tick(); req0_data = 8'h5A; req0_valid = 1'b1;       // cycle 10
    tick(); req0_valid = 1'b0;                          // cycle 11
    tick();                                             // cycle 12
    n_checks++; if (tx_start !== 1'b1 || tx_data !== 8'h5A || grant !== 2'b01) begin n_fail++; $display("FAIL rstmid_resume: got start=%b data=%h grant=%b want 1/5A/01", tx_start, tx_data, grant); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_overflow();
    test_drain_accept();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_uart_tx_arb
